// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell processes one operand bit pair per clock,
// LSB first, with the carry held in a flip-flop between bits.

module fulladder_new (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] s_shifted;

    fulladder_new u_fa (
        .x     (a_sh[0]),
        .y     (b_sh[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    assign s_shifted = {fa_s, s_sh[WIDTH-1:1]};
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= c_in0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    s_sh    <= s_shifted;
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    carry_q <= fa_c;
                    cnt     <= cnt + 1'b1;
                    // Last bit: carry_q is the carry into the MSB, fa_c the carry out.
                    if (cnt == LAST) begin
                        sum   <= s_shifted;
                        c_out <= fa_c;
                        ovf   <= carry_q ^ fa_c;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: stimulus pushes arithmetic expectations,
// a negedge monitor checks busy/done timing and the held result registers.

module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in0 = 1'b0;
    logic         busy, done, c_out, ovf;
    logic [W-1:0] sum;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in0 (c_in0),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           next_acc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] last_s = '0;
    logic         last_c = 1'b0;
    logic         last_o = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer addition and sign rule for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input int acc);
        exp_t e;
        logic [W:0] t;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s = t[W-1:0];
        e.c = t[W];
        e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        e.acc = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        logic exp_busy, exp_done;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_sum", sum, 0);
            chk("rst_cout", c_out, 0);
            chk("rst_ovf", ovf, 0);
        end else begin
            exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].acc + W);
            exp_done = (q.size() > 0) && (cyc == q[0].acc + W);
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("busy_and_done", busy & done, 0);
            if (exp_done) begin
                exp_t e;
                e = q.pop_front();
                last_s = e.s;
                last_c = e.c;
                last_o = e.o;
            end
            chk("sum", sum, last_s);
            chk("c_out", c_out, last_c);
            chk("ovf", ovf, last_o);
        end
    end

    // Holds start until the model says the DUT is idle; optionally keeps it high.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input bit hold);
        int guard = 0;
        start = 1'b1;
        a = x;
        b = y;
        c_in0 = ci;
        while (guard < 4 * W) begin
            @(posedge clk);
            #1;
            guard++;
            if (cyc >= next_acc) begin
                q.push_back(model(x, y, ci, cyc));
                next_acc = cyc + W + 2;
                break;
            end
        end
        if (guard >= 4 * W) chk("accept_timeout", guard, 0);
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 3 * W) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_acc = cyc + 1;
        repeat (20) @(posedge clk);
        #1;

        issue(8'h01, 8'h01, 1'b0, 0); drain();
        issue(8'hFF, 8'h01, 1'b0, 0); drain();
        issue(8'h00, 8'h00, 1'b1, 0); drain();
        issue(8'h7F, 8'h01, 1'b0, 0); drain();
        issue(8'h80, 8'h80, 1'b0, 0); drain();

        // Request during RUN must be ignored.
        issue(8'h10, 8'h20, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Start held high: back-to-back accepts at WIDTH+2 spacing.
        issue(8'h33, 8'h44, 1'b0, 1);
        issue(8'hC8, 8'h64, 1'b1, 0);
        drain();

        // Asynchronous reset mid-RUN.
        issue(8'h11, 8'h22, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        last_s = '0; last_c = 1'b0; last_o = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_sum", sum, 0);
        chk("async_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_acc = cyc + 1;
        issue(8'h03, 8'h04, 1'b0, 0); drain();

        for (int i = 0; i < 30; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        start = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
